fp_mul_arbiter: RTL

Shares one single-precision floating-point multiplier between two requesters. Each requester gets a valid/ready operand port and a valid/ready result port. The block round-robin arbitrates issue slots and registers the operands into the multiplier. It tracks which requester owns each in-flight operation and routes `out` and `exception` back to that requester. It sits between the multiplier instance and the two client datapaths, and is the only driver of the multiplier's A/B inputs.

---
 rtl/fp_mul_arbiter_if.sv | 31 +++
 rtl/fp_mul_arbiter.sv | 91 +++++++++
 2 files changed

// File: rtl/fp_mul_arbiter_if.sv
// rtl/fp_mul_arbiter_if.sv - client and multiplier signal bundle for fp_mul_arbiter
interface fp_mul_arbiter_if;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data;
  logic        rsp0_exc, rsp1_exc;
  logic [31:0] mul_a, mul_b;
  logic [31:0] mul_out;
  logic        mul_exc;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, rsp0_exc, rsp1_exc,
    input  rsp0_ready, rsp1_ready,
    output mul_a, mul_b,
    input  mul_out, mul_exc
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, rsp0_exc, rsp1_exc,
    output rsp0_ready, rsp1_ready,
    input  mul_a, mul_b,
    output mul_out, mul_exc
  );
endinterface

// File: rtl/fp_mul_arbiter.sv
// rtl/fp_mul_arbiter.sv - round-robin sharing of one FP multiplier between two requesters
// Tags ride alongside the multiplier pipeline so each result returns to its issuer.
module fp_mul_arbiter #(
  parameter int MUL_LAT = 1
) (
  input  logic              control,
  input  logic              reset,
  fp_mul_arbiter_if.slave   arb
);
  logic [1:0]        req_valid, rsp_ready, eligible, gnt, rsp_hs;
  logic [1:0]        busy_q, busy_d, rsp_valid_q, rsp_valid_d;
  logic [1:0][31:0]  rsp_data_q, rsp_data_d;
  logic [1:0]        rsp_exc_q, rsp_exc_d;
  logic              last_q, last_d;
  logic              hs, gnt_id;
  logic [31:0]       mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [MUL_LAT:0]  tag_v_q, tag_v_d, tag_id_q, tag_id_d;
  logic              cap, cap_id;

  assign req_valid = {arb.req1_valid, arb.req0_valid};
  assign rsp_ready = {arb.rsp1_ready, arb.rsp0_ready};
  assign eligible  = req_valid & ~busy_q;
  assign rsp_hs    = rsp_valid_q & rsp_ready;

  // Ready only rises for an eligible requester, so any ready is also a handshake.
  always_comb begin
    gnt = eligible;
    if (&eligible) gnt = last_q ? 2'b01 : 2'b10;
  end
  assign hs     = |gnt;
  assign gnt_id = gnt[1];

  assign cap    = tag_v_q[MUL_LAT];
  assign cap_id = tag_id_q[MUL_LAT];

  always_comb begin
    tag_v_d     = {tag_v_q[MUL_LAT-1:0], hs};
    tag_id_d    = {tag_id_q[MUL_LAT-1:0], gnt_id};
    busy_d      = (busy_q | gnt) & ~rsp_hs;
    last_d      = hs ? gnt_id : last_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    if (hs) begin
      mul_a_d = gnt_id ? arb.req1_a : arb.req0_a;
      mul_b_d = gnt_id ? arb.req1_b : arb.req0_b;
    end
    rsp_valid_d = rsp_valid_q & ~rsp_hs;
    rsp_data_d  = rsp_data_q;
    rsp_exc_d   = rsp_exc_q;
    if (cap) begin
      rsp_valid_d[cap_id] = 1'b1;
      rsp_data_d[cap_id]  = arb.mul_out;
      rsp_exc_d[cap_id]   = arb.mul_exc;
    end
  end

  always_ff @(posedge control or negedge reset) begin
    if (!reset) begin
      tag_v_q     <= '0;
      tag_id_q    <= '0;
      busy_q      <= '0;
      last_q      <= 1'b1;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_exc_q   <= '0;
    end else begin
      tag_v_q     <= tag_v_d;
      tag_id_q    <= tag_id_d;
      busy_q      <= busy_d;
      last_q      <= last_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_exc_q   <= rsp_exc_d;
    end
  end

  assign arb.req0_ready = gnt[0];
  assign arb.req1_ready = gnt[1];
  assign arb.rsp0_valid = rsp_valid_q[0];
  assign arb.rsp1_valid = rsp_valid_q[1];
  assign arb.rsp0_data  = rsp_data_q[0];
  assign arb.rsp1_data  = rsp_data_q[1];
  assign arb.rsp0_exc   = rsp_exc_q[0];
  assign arb.rsp1_exc   = rsp_exc_q[1];
  assign arb.mul_a      = mul_a_q;
  assign arb.mul_b      = mul_b_q;
endmodule
